accel_series_wrapper: RTL and testbench
=======================================

# accel_series_wrapper

Parametrised successor to the single-shot accelerator wrapper. On `start`, it latches operands `U` and `V` and iterates the recurrence x(i+1) = x(i)·V + U, starting from x(0) = U, for `ITER` steps. Each result goes into an internal output FIFO, which drains to the memory write port through a `wr_req`/`wr_ack` handshake. The block sits between the control FSM that issues `start` and the result memory. It adds two things the previous generation lacked: write back-pressure and overflow reporting.

## Interface
- `VW`, 5: width of operand `V`.
- `UW`, 2: width of operand `U`.
- `DW`, 21: result and write-data width.
- `ITER`, 8: number of results produced per `start` (≥1).
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).

Ports:
- `clk`, input, 1: system clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-low. Clears all state.
- `start`, input, 1: single-cycle request. Sampled only in IDLE.
- `U`, input, `UW`: additive operand. Sampled when `start` is accepted.
- `V`, input, `VW`: multiplicative operand. Sampled when `start` is accepted.
- `wr_ack`, input, 1: sink accepts `wr_data` this cycle.
- `busy`, output, 1: high in RUN and DRAIN.
- `done`, output, 1: one-cycle pulse when the last result has been accepted.
- `wr_req`, output, 1: FIFO non-empty; `wr_data` is valid.
- `wr_data`, output, `DW`: FIFO head (show-ahead).
- `overflow`, output, 1: sticky. Set if any untruncated x·V+U exceeded `DW` bits. Cleared on accepted `start`.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`: latch `U`, `V`; set x = zero-extended `U`, cnt = 0, `overflow` = 0.
  - RUN: each cycle the FIFO is not full:
    - compute x' = x·V + U at full width (`DW`+`VW`+1 bits);
    - push x'[`DW`-1:0] into the FIFO; store it as the new x;
    - increment cnt;
    - set `overflow` if any bit above `DW`-1 of x' is set.
  - RUN: when the push with cnt = `ITER`-1 occurs → DRAIN.
  - RUN: FIFO full → stall. No compute, x and cnt held.
  - DRAIN → DONE when the FIFO is empty, i.e. the last entry has been popped.
  - DONE: `done` = 1 for one cycle → IDLE.
- `start` is ignored in RUN, DRAIN and DONE. Operands changing after acceptance have no effect.
- FIFO push: RUN && !full, where full is the registered count = `FIFO_DEPTH`.
  - A simultaneous pop does not permit a push into a full FIFO that cycle.
- FIFO pop: `wr_req` && `wr_ack`.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- `wr_ack` while `wr_req` = 0 is ignored.
- Pointers wrap modulo `FIFO_DEPTH`.
- Results are emitted strictly in order x(1)…x(`ITER`). No loss or duplication under any `wr_ack` pattern.
- Reset (any state, including mid-RUN or mid-DRAIN) → IDLE immediately. FIFO emptied, all outputs 0.

## Timing
- Reset values: `busy`=0, `done`=0, `wr_req`=0, `wr_data`=0, `overflow`=0.
- `start` high at edge k: `busy`=1 after edge k. First push at edge k+1. `wr_req`=1 after edge k+1.
- With `wr_ack` tied high:
  - one result per cycle, no FIFO build-up;
  - last pop at edge k+`ITER`+1;
  - DRAIN → DONE at edge k+`ITER`+2;
  - `done` high for the cycle after that edge; `busy` low in the same cycle `done` is high.
- With `wr_ack` low, RUN stalls after `FIFO_DEPTH` pushes. It resumes the cycle after a pop frees a slot.
- `overflow` updates on the same edge as the offending push. It stays valid through DONE and IDLE until the next accepted `start`.
- `wr_data` is stable while `wr_req`=1 and `wr_ack`=0.

## Test plan
- U=1, V=2, `wr_ack`=1 → `wr_data` sequence 3,7,15,31,63,127,255,511; one `done` pulse; `overflow`=0; `busy` spans exactly `ITER`+2 cycles.
- U=0, V=0 → eight writes of 0; `done` pulses; `overflow`=0.
- U=3, V=31 → writes 96, 2979, 92352, then 765763 (2862915 mod 2^21); `overflow` rises on the 4th push and stays 1 after `done`.
- U=1, V=2, `wr_ack` held 0 for 10 cycles then 1 → exactly 4 entries buffered, RUN stalls, `wr_data`=3 held stable; then the full ordered sequence drains; `done` pulses once.
- `wr_ack` toggling 1/0 each cycle → order preserved, no duplicates or drops; a second `start` pulsed mid-RUN is ignored.
- `rst` asserted after the 3rd write → all outputs 0 immediately; a subsequent `start` with U=1, V=2 restarts from 3.

Source files
------------

// File: rtl/accel_series_wrapper.sv
// accel_series_wrapper: iterates x <= x*V + U for ITER steps, buffering results in a show-ahead FIFO drained over wr_req/wr_ack.
module accel_series_wrapper #(
  parameter int VW = 5,
  parameter int UW = 2,
  parameter int DW = 21,
  parameter int ITER = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [UW-1:0] U,
  input  logic [VW-1:0] V,
  input  logic          wr_ack,
  output logic          busy,
  output logic          done,
  output logic          wr_req,
  output logic [DW-1:0] wr_data,
  output logic          overflow
);
  localparam int XW = DW + VW + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [UW-1:0] u_r;
  logic [VW-1:0] v_r;
  logic [DW-1:0] x;
  logic [XW-1:0] x_nx;
  logic [CW-1:0] cnt;
  logic [AW-1:0] wp, rp;
  logic [FW-1:0] fifo_cnt;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic full, push, pop, last, accept;
  assign x_nx = XW'(x) * XW'(v_r) + XW'(u_r);
  assign full = fifo_cnt == FW'(FIFO_DEPTH);
  assign push = (state == RUN) && !full;
  assign pop = wr_req && wr_ack;
  assign last = cnt == CW'(ITER - 1);
  assign accept = (state == IDLE) && start;
  assign busy = (state == RUN) || (state == DRAIN);
  assign done = state == DONE;
  assign wr_req = fifo_cnt != '0;
  assign wr_data = wr_req ? mem[rp] : '0;
  always_comb begin
    state_nx = state;
    state_nx = accept ? RUN :
               (push && last) ? DRAIN :
               (state == DRAIN && fifo_cnt == '0) ? DONE :
               (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      u_r <= '0;
      v_r <= '0;
      x <= '0;
      cnt <= '0;
      overflow <= 1'b0;
      wp <= '0;
      rp <= '0;
      fifo_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        u_r <= U;
        v_r <= V;
        x <= DW'(U);
        cnt <= '0;
        overflow <= 1'b0;
      end else if (push) begin
        x <= x_nx[DW-1:0];
        cnt <= cnt + CW'(1);
        overflow <= overflow | (|x_nx[XW-1:DW]);
      end
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      fifo_cnt <= fifo_cnt + FW'(push) - FW'(pop);
    end
  end
  // Storage needs no reset: wr_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= x_nx[DW-1:0];
  end
endmodule

// File: tb/tb_accel_series_wrapper.sv
// tb_accel_series_wrapper: scoreboard bench; stimulus queues expected writes, a negedge monitor checks each accepted write.
module tb_accel_series_wrapper;
  localparam int ITER = 8;
  typedef logic [20:0] seq_t [8];
  logic clk = 0, rst = 0, start = 0, wr_ack = 0;
  logic [1:0] U = 0;
  logic [4:0] V = 0;
  logic busy, done, wr_req, overflow;
  logic [20:0] wr_data;
  int tests = 0, fails = 0, done_cnt = 0, done_base = 0, busy_cnt = 0, pop_cnt = 0, mode = 0;
  logic hold = 0;
  logic [20:0] hold_data = 0;
  logic [20:0] exp_q [$];
  seq_t s12 = '{21'd3, 21'd7, 21'd15, 21'd31, 21'd63, 21'd127, 21'd255, 21'd511};
  seq_t s00 = '{default: 21'd0};
  seq_t s331 = '{21'd96, 21'd2979, 21'd92352, 21'd765763, 21'd669984, 21'd1895139, 21'd29056, 21'd900739};

  accel_series_wrapper dut (
    .clk(clk), .rst(rst), .start(start), .U(U), .V(V), .wr_ack(wr_ack),
    .busy(busy), .done(done), .wr_req(wr_req), .wr_data(wr_data), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("busy_low_with_done", busy, 0);
    end
    if (busy) busy_cnt++;
    if (hold && wr_req && rst) check("wr_data_stable", wr_data, hold_data);
    if (wr_req && wr_ack) begin
      if (exp_q.size() == 0) check("unexpected_write", 1, 0);
      else check("wr_data", wr_data, exp_q.pop_front());
      pop_cnt++;
    end
    hold = wr_req && !wr_ack;
    hold_data = wr_data;
  end

  // mode: 0 = ack low, 1 = ack high, 2 = ack toggles every cycle
  initial forever begin
    @(posedge clk);
    #1 wr_ack = (mode == 1) ? 1'b1 : (mode == 2) ? ~wr_ack : 1'b0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic launch(input logic [1:0] u, input logic [4:0] v, input seq_t seq);
    foreach (seq[i]) exp_q.push_back(seq[i]);
    @(posedge clk);
    #1 U = u; V = v; start = 1;
    busy_cnt = 0;
    done_base = done_cnt;
    @(posedge clk);
    #1 start = 0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic finish_chk(input string name, input logic ovf, input int busy_exp);
    for (int i = 0; i < 300 && done_cnt == done_base; i++) @(negedge clk);
    check({name, "_done_seen"}, done_cnt != done_base, 1);
    repeat (3) @(negedge clk);
    check({name, "_done_once"}, done_cnt - done_base, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_overflow"}, overflow, ovf);
    check({name, "_idle_busy"}, busy, 0);
    if (busy_exp > 0) check({name, "_busy_span"}, busy_cnt, busy_exp);
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_wr_req"}, wr_req, 0);
    check({name, "_wr_data"}, wr_data, 0);
    check({name, "_overflow"}, overflow, 0);
  endtask

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rst = 1;
    mode = 1;
    repeat (2) @(posedge clk);
    launch(2'd1, 5'd2, s12);
    finish_chk("t1", 0, ITER + 2);
    launch(2'd0, 5'd0, s00);
    finish_chk("t2", 0, 0);
    launch(2'd3, 5'd31, s331);
    repeat (4) @(negedge clk);
    check("t3_ovf_before_4th", overflow, 0);
    @(negedge clk);
    check("t3_ovf_at_4th", overflow, 1);
    finish_chk("t3", 1, 0);
    mode = 0;
    launch(2'd1, 5'd2, s12);
    repeat (10) @(negedge clk);
    check("t4_stall_req", wr_req, 1);
    check("t4_stall_data", wr_data, 3);
    check("t4_stall_fill", dut.fifo_cnt, 4);
    check("t4_stall_busy", busy, 1);
    mode = 1;
    finish_chk("t4", 0, 0);
    mode = 2;
    launch(2'd1, 5'd2, s12);
    repeat (3) @(posedge clk);
    #1 U = 2'd3; V = 5'd31; start = 1;
    @(posedge clk);
    #1 start = 0;
    finish_chk("t5", 0, 0);
    mode = 1;
    p0 = pop_cnt;
    launch(2'd1, 5'd2, s12);
    for (int i = 0; i < 100 && pop_cnt < p0 + 3; i++) @(negedge clk);
    check("t6_three_writes", pop_cnt - p0, 3);
    @(posedge clk);
    #1 rst = 0;
    #1 check_zero("t6_reset");
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1;
    launch(2'd1, 5'd2, s12);
    finish_chk("t6_restart", 0, ITER + 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
